// File: rtl/matrix_unloader_if.sv
// Stream-side bundle for matrix_unloader: snapshot inputs, element stream and status pulses.
// slave is the unloader's view; master is the view of whatever drives it.
interface matrix_unloader_if #(
  parameter int DW    = 16,
  parameter int MAXD  = 4,
  parameter int FLATW = DW * MAXD * MAXD
);
  localparam int AW = $clog2(MAXD);

  logic [FLATW-1:0] res_mat;
  logic [3:0]       r1;
  logic [3:0]       c2;
  logic             start;
  logic             out_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic [AW-1:0]    out_row;
  logic [AW-1:0]    out_col;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             err;

  modport slave (
    input  res_mat, r1, c2, start, out_ready,
    output out_valid, out_data, out_row, out_col, out_last, busy, done, err
  );

  modport master (
    output res_mat, r1, c2, start, out_ready,
    input  out_valid, out_data, out_row, out_col, out_last, busy, done, err
  );
endinterface

// File: rtl/matrix_unloader.sv
// Snapshots a flat result matrix on start and streams it out one element per
// valid/ready handshake in row-major order, with row/col tags and a last flag.
module matrix_unloader #(
  parameter int DW    = 16,
  parameter int MAXD  = 4,
  parameter int FLATW = DW * MAXD * MAXD
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  matrix_unloader_if.slave bus
);
  localparam int NE = MAXD * MAXD;
  localparam int AW = $clog2(MAXD);
  localparam int IW = $clog2(NE);
  localparam int NW = $clog2(NE + 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [FLATW-1:0] shadow_q, shadow_d;
  logic [3:0]       c2_q, c2_d;
  logic [NW-1:0]    n_q, n_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [AW-1:0]    row_q, row_d;
  logic [AW-1:0]    col_q, col_d;
  logic             err_q, err_d;

  logic             dims_ok;
  logic [NW-1:0]    n_new;
  logic             last_elem;
  logic             stream;

  assign dims_ok   = (bus.r1 != 4'd0) && (bus.r1 <= 4'(MAXD)) &&
                     (bus.c2 != 4'd0) && (bus.c2 <= 4'(MAXD));
  assign n_new     = NW'(bus.r1) * NW'(bus.c2);
  assign last_elem = (NW'(idx_q) == n_q - NW'(1));
  assign stream    = (state_q == S_STREAM);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    c2_d     = c2_q;
    n_d      = n_q;
    idx_d    = idx_q;
    row_d    = row_q;
    col_d    = col_q;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (dims_ok) begin
            // Left-justify so element 0 always sits in the top DW bits.
            shadow_d = bus.res_mat << (DW * (NE - int'(n_new)));
            c2_d     = bus.c2;
            n_d      = n_new;
            idx_d    = '0;
            row_d    = '0;
            col_d    = '0;
            state_d  = S_STREAM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (bus.out_ready) begin
          shadow_d = shadow_q << DW;
          idx_d    = idx_q + IW'(1);
          if (4'(col_q) == c2_q - 4'd1) begin
            col_d = '0;
            row_d = row_q + AW'(1);
          end else begin
            col_d = col_q + AW'(1);
          end
          if (last_elem) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = stream;
    bus.out_data  = stream ? shadow_q[FLATW-1 -: DW] : '0;
    bus.out_row   = stream ? row_q : '0;
    bus.out_col   = stream ? col_q : '0;
    bus.out_last  = stream && last_elem;
    bus.busy      = stream;
    bus.done      = (state_q == S_DONE);
    bus.err       = err_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      c2_q     <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      c2_q     <= c2_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_matrix_unloader.sv
// Directed and randomized checks of matrix_unloader against a row-major element model.
module tb_matrix_unloader;
  logic clk = 1'b0;
  logic rst_n;
  int   n_asserts = 0;
  int   n_fail = 0;

  matrix_unloader_if #(.DW(16), .MAXD(4), .FLATW(256)) bus ();

  matrix_unloader #(.DW(16), .MAXD(4), .FLATW(256)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Element k of an N-element matrix sits at bits [(N-k)*16-1 : (N-k)*16-16].
  function automatic logic [15:0] exp_elem(input logic [255:0] m, input int n, input int k);
    return 16'(m >> ((n - 1 - k) * 16));
  endfunction

  function automatic logic [255:0] rand_mat();
    logic [255:0] m;
    for (int i = 0; i < 8; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  // Called at a negedge; start is seen by the next posedge.
  task automatic start_req(input logic [255:0] mat, input int r1, input int c2);
    bus.res_mat = mat;
    bus.r1      = 4'(r1);
    bus.c2      = 4'(c2);
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  // mode: 0 ready always, 1 ready toggling 1,0,.., 2 random ready.
  // stop_after >= 0 returns after that many accepts; poke_at re-pulses start
  // with a different matrix while element poke_at is pending.
  task automatic drain(input logic [255:0] mat, input int r1, input int c2, input int mode,
                       input int stop_after, input int poke_at, output int cycles);
    int  n = r1 * c2;
    int  k = 0;
    bit  rdy;
    cycles = 0;
    while (k < n && k != stop_after) begin
      if (cycles > 200) begin
        check("stream_timeout", 32'(cycles), 32'd200);
        break;
      end
      check("out_valid", 32'(bus.out_valid), 32'd1);
      check("out_data",  32'(bus.out_data),  32'(exp_elem(mat, n, k)));
      check("out_row",   32'(bus.out_row),   32'(k / c2));
      check("out_col",   32'(bus.out_col),   32'(k % c2));
      check("out_last",  32'(bus.out_last),  32'(k == n - 1));
      check("busy",      32'(bus.busy),      32'd1);
      check("err_stream", 32'(bus.err),      32'd0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cycles % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = rdy;
      if (k == poke_at) begin
        bus.start   = 1'b1;
        bus.res_mat = ~mat;
        bus.r1      = 4'd1;
        bus.c2      = 4'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cycles++;
      if (rdy) k++;
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    if (k == n) begin
      check("done_pulse", 32'(bus.done),      32'd1);
      check("valid_done", 32'(bus.out_valid), 32'd0);
      check("busy_done",  32'(bus.busy),      32'd0);
      @(negedge clk);
      check("done_clear", 32'(bus.done),      32'd0);
      check("err_after",  32'(bus.err),       32'd0);
      check("valid_idle", 32'(bus.out_valid), 32'd0);
    end
  endtask

  initial begin
    logic [255:0] m;
    int cyc;
    int r1;
    int c2;

    rst_n = 1'b0;
    bus.res_mat = '0; bus.r1 = '0; bus.c2 = '0; bus.start = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data",  32'(bus.out_data),  32'd0);
    check("rst_row",   32'(bus.out_row),   32'd0);
    check("rst_col",   32'(bus.out_col),   32'd0);
    check("rst_last",  32'(bus.out_last),  32'd0);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_done",  32'(bus.done),      32'd0);
    check("rst_err",   32'(bus.err),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2x2 with ready held high: four consecutive cycles
    m = '0; m[63:0] = 64'h0013_0016_002B_0032;
    start_req(m, 2, 2);
    drain(m, 2, 2, 0, -1, -1, cyc);
    check("2x2_cycles", 32'(cyc), 32'd4);

    // 4x4 with alternating backpressure
    m = '0;
    for (int k = 0; k < 16; k++) m[(16 - k) * 16 - 1 -: 16] = 16'(k + 1);
    start_req(m, 4, 4);
    drain(m, 4, 4, 1, -1, -1, cyc);
    check("4x4_cycles", 32'(cyc), 32'd31);

    // illegal dimensions
    start_req(m, 5, 2);
    check("err_r1_5",   32'(bus.err),       32'd1);
    check("ill_valid",  32'(bus.out_valid), 32'd0);
    check("ill_busy",   32'(bus.busy),      32'd0);
    @(negedge clk);
    check("err_clear",  32'(bus.err),       32'd0);
    start_req(m, 0, 3);
    check("err_r1_0",   32'(bus.err),       32'd1);
    check("ill_valid2", 32'(bus.out_valid), 32'd0);
    check("ill_busy2",  32'(bus.busy),      32'd0);
    @(negedge clk);
    check("err_clear2", 32'(bus.err),       32'd0);

    // 3x3 with a start pulse and new matrix mid-stream
    m = rand_mat();
    start_req(m, 3, 3);
    drain(m, 3, 3, 0, -1, 4, cyc);
    check("3x3_cycles", 32'(cyc), 32'd9);

    // asynchronous reset after two of four elements
    m = rand_mat();
    start_req(m, 2, 2);
    drain(m, 2, 2, 0, 2, -1, cyc);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_busy",  32'(bus.busy),      32'd0);
    check("arst_done",  32'(bus.done),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_no_done", 32'(bus.done), 32'd0);
    m = rand_mat();
    start_req(m, 2, 2);
    drain(m, 2, 2, 0, -1, -1, cyc);

    // 1x3 non-square
    m = '0; m[47:0] = 48'h000A_000B_000C;
    start_req(m, 1, 3);
    drain(m, 1, 3, 0, -1, -1, cyc);

    // randomized dimensions, data, backpressure and stray start pulses
    for (int t = 0; t < 12; t++) begin
      r1 = $urandom_range(1, 4);
      c2 = $urandom_range(1, 4);
      m  = rand_mat();
      start_req(m, r1, c2);
      drain(m, r1, c2, $urandom_range(0, 2), -1, $urandom_range(0, r1 * c2 - 1), cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_unloader.md
Name: matrix_unloader

Overview:
- Reads the flat 256-bit result matrix produced by the matrix multiplier and streams it out one 16-bit element per handshake, in row-major order, over a valid/ready interface.
- Sits between the multiplier's res_mat output and the serial output path.
- Captures a snapshot on start, so the multiplier may change res_mat while streaming is in progress.

Parameters:
- DW, 16, element width in bits.
- MAXD, 4, maximum row/column dimension.
- FLATW, 256, flat matrix width in bits (DW*MAXD*MAXD).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- res_mat  input  FLATW  result matrix. Elements are packed at the low end, MSB-first: for N elements, element k occupies bits [(N-k)*16-1 : (N-k)*16-16].
- R1  input  4  result row count, valid range 1..4.
- C2  input  4  result column count, valid range 1..4.
- start  input  1  single-cycle request to capture res_mat/R1/C2 and begin streaming.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_valid  output  1  out_data holds a valid element.
- out_data  output  DW  current element.
- out_row  output  2  row index of the current element.
- out_col  output  2  column index of the current element.
- out_last  output  1  current element is the final one (index N-1).
- busy  output  1  high in the STREAM state.
- done  output  1  one-cycle pulse after the last element is accepted.
- err  output  1  one-cycle pulse when start is seen with illegal dimensions.

Behaviour:
- Reset (asynchronous, RST_N=0): state=IDLE. All outputs are 0, the shadow register is 0, and all counters are 0.
- States are IDLE, STREAM and DONE.
- IDLE:
  - start=1 with R1 and C2 both in 1..4:
    - N=R1*C2, an unsigned 5-bit product.
    - Shadow register is loaded with res_mat shifted left by 16*(16-N), so that element 0 sits in shadow[255:240].
    - Latch R1 and C2; clear row, col and the element index; go to STREAM.
  - start=1 with R1 or C2 equal to 0 or greater than 4: err=1 for the next cycle, stay in IDLE, no output.
  - start=0: stay in IDLE.
- STREAM:
  - out_valid=1; out_data=shadow[255:240]; out_row and out_col give the current position.
  - out_last=1 when index==N-1.
  - Handshake is out_valid and out_ready in the same cycle. On a handshake:
    - shadow shifts left by 16;
    - index increments;
    - col increments; when col==C2-1 it wraps to 0 and row increments.
  - A handshake with out_last=1 moves to DONE.
  - With out_ready=0, out_data/out_row/out_col/out_last hold stable and out_valid stays high; out_valid never drops until the element is accepted.
- DONE:
  - One cycle only: done=1, out_valid=0, then IDLE.
  - start is ignored in this cycle.
- Latency:
  - Start on edge t gives out_valid=1 from edge t+1.
  - With out_ready held at 1, N elements are delivered in N consecutive cycles, and done pulses in cycle t+N+1.
- start asserted while in STREAM or DONE is ignored: no capture, no err, no effect on the current stream.
- res_mat, R1 and C2 changes after capture have no effect until the next accepted start.
- Reset mid-stream returns immediately to IDLE, with out_valid=0 and no done pulse.
- A product is never truncated: N is at most 16, and the shift amount is at most 240 bits.
- busy=1 exactly while in STREAM.

Test Plan:
- 2x2 stream:
  - Stimulus: R1=C2=2, res_mat[63:0]=0x0013_0016_002B_0032, start pulse, out_ready=1.
  - Required: out_data is 0x0013, 0x0016, 0x002B, 0x0032 on 4 consecutive cycles, with (row,col) = (0,0), (0,1), (1,0), (1,1); out_last only on 0x0032; done one cycle later.
- 4x4 with backpressure:
  - Stimulus: res_mat words 1..16 top to bottom (word 0x0001 in [255:240]); out_ready toggles 1,0,1,0.
  - Required: 16 elements 0x0001..0x0010 in order; out_data held stable during every ready=0 cycle; 31 cycles from first valid to last accept.
- Illegal dimensions:
  - Stimulus: start with R1=5, C2=2, then start with R1=0, C2=3.
  - Required: err pulses once for each start; out_valid stays 0; busy stays 0.
- Start while busy:
  - Stimulus: 3x3 stream; mid-stream, change res_mat and pulse start.
  - Required: the original 9 elements complete unchanged; no err; exactly one done pulse.
- Reset mid-stream:
  - Stimulus: drive RST_N low asynchronously after 2 of 4 elements of a 2x2 stream.
  - Required: out_valid, busy and done go to 0 immediately; a fresh start afterwards streams from element 0.
- Non-square 1x3:
  - Stimulus: R1=1, C2=3, res_mat[47:0]=0x000A_000B_000C.
  - Required: out_data 0x000A, 0x000B, 0x000C with col 0, 1, 2 and row 0; out_last on 0x000C.
